// File: rtl/apu_dsm_dac.sv
// APU audio output: mixes four channels, applies a click-free mute/unmute gain ramp,
// smooths with a one-pole IIR low-pass and emits a first-order delta-sigma bitstream.
module apu_dsm_dac #(
    parameter int SHIFT = 3
) (
    input  logic       apu_clk,
    input  logic       rst_n,
    input  logic       enable_240hz,
    input  logic       mute,
    input  logic [3:0] pulse1_in,
    input  logic [3:0] pulse2_in,
    input  logic [3:0] tri_in,
    input  logic [3:0] noise_in,
    output logic       dsm_out,
    output logic [5:0] level,
    output logic       active,
    output logic       silent
);

    typedef enum logic [1:0] {
        MUTED     = 2'd0,
        RAMP_UP   = 2'd1,
        ACTIVE    = 2'd2,
        RAMP_DOWN = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic        [4:0]  gain;
    logic        [4:0]  gain_nxt;
    logic        [5:0]  mix_q;
    logic        [5:0]  scaled_q;
    logic        [9:0]  prod;
    logic        [15:0] y;
    logic        [15:0] acc;
    logic signed [16:0] d;

    // The step direction follows the new state, so a mute change and a strobe
    // on the same edge both take effect and reversal never jumps the gain.
    always_comb begin
        state_nxt = state;
        gain_nxt  = gain;
        case (state)
            MUTED:     if (!mute) state_nxt = RAMP_UP;
            RAMP_UP:   if (mute)  state_nxt = RAMP_DOWN;
            ACTIVE:    if (mute)  state_nxt = RAMP_DOWN;
            RAMP_DOWN: if (!mute) state_nxt = RAMP_UP;
            default:              state_nxt = MUTED;
        endcase
        if (enable_240hz) begin
            if (state_nxt == RAMP_UP && gain < 5'd16)
                gain_nxt = gain + 5'd1;
            else if (state_nxt == RAMP_DOWN && gain != 5'd0)
                gain_nxt = gain - 5'd1;
        end
        if (state_nxt == RAMP_UP && gain_nxt == 5'd16)
            state_nxt = ACTIVE;
        else if (state_nxt == RAMP_DOWN && gain_nxt == 5'd0)
            state_nxt = MUTED;
    end

    always_ff @(posedge apu_clk) begin
        if (!rst_n) begin
            state <= MUTED;
            gain  <= 5'd0;
        end else begin
            state <= state_nxt;
            gain  <= gain_nxt;
        end
    end

    assign prod = {4'd0, mix_q} * {5'd0, gain};
    // Negative d floors to at least -1, so a decay always lands exactly on 0.
    assign d    = $signed({1'b0, scaled_q, 10'd0}) - $signed({1'b0, y});

    always_ff @(posedge apu_clk) begin
        if (!rst_n) begin
            mix_q    <= 6'd0;
            scaled_q <= 6'd0;
            y        <= 16'd0;
            acc      <= 16'd0;
            dsm_out  <= 1'b0;
        end else begin
            mix_q          <= 6'(pulse1_in) + 6'(pulse2_in) + 6'(tri_in) + 6'(noise_in);
            scaled_q       <= 6'(prod >> 4);
            y              <= y + 16'(d >>> SHIFT);
            {dsm_out, acc} <= {1'b0, acc} + {1'b0, y};
        end
    end

    assign level  = y[15:10];
    assign active = (gain == 5'd16);
    assign silent = (gain == 5'd0);

endmodule

// File: tb/tb_apu_dsm_dac.sv
// Directed self-checking bench for apu_dsm_dac (SHIFT = 3).
module tb_apu_dsm_dac;

    logic       apu_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable_240hz = 1'b0;
    logic       mute = 1'b1;
    logic [3:0] pulse1_in = 4'd15;
    logic [3:0] pulse2_in = 4'd15;
    logic [3:0] tri_in = 4'd15;
    logic [3:0] noise_in = 4'd15;
    logic       dsm_out;
    logic [5:0] level;
    logic       active;
    logic       silent;

    int checks = 0;
    int errors = 0;
    int ones;

    apu_dsm_dac #(.SHIFT(3)) dut (
        .apu_clk      (apu_clk),
        .rst_n        (rst_n),
        .enable_240hz (enable_240hz),
        .mute         (mute),
        .pulse1_in    (pulse1_in),
        .pulse2_in    (pulse2_in),
        .tri_in       (tri_in),
        .noise_in     (noise_in),
        .dsm_out      (dsm_out),
        .level        (level),
        .active       (active),
        .silent       (silent)
    );

    always #5 apu_clk = ~apu_clk;

    task automatic tick();
        @(posedge apu_clk);
        #1;
    endtask

    task automatic gap(input int n);
        repeat (n) tick();
    endtask

    task automatic strobe();
        enable_240hz = 1'b1;
        tick();
        enable_240hz = 1'b0;
    endtask

    task automatic set_all(input logic [3:0] v);
        pulse1_in = v;
        pulse2_in = v;
        tri_in    = v;
        noise_in  = v;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset held with every input high
        tick();
        tick();
        check("rst_dsm_out", dsm_out, 0);
        check("rst_level", level, 0);
        check("rst_active", active, 0);
        check("rst_silent", silent, 1);
        check("rst_gain", dut.gain, 0);

        // Muted: strobes must not move the gain
        rst_n = 1'b1;
        enable_240hz = 1'b1;
        ones = 0;
        repeat (100) begin
            tick();
            ones += dsm_out;
        end
        enable_240hz = 1'b0;
        check("muted_gain", dut.gain, 0);
        check("muted_ones", ones, 0);

        // Unmute: gain holds at 0 until the first strobe
        mute = 1'b0;
        tick();
        check("unmute_gain", dut.gain, 0);
        check("unmute_silent", silent, 1);
        for (int k = 1; k <= 16; k++) begin
            gap(7);
            strobe();
            check("up_gain", dut.gain, k);
            check("up_active", active, (k == 16) ? 1 : 0);
            check("up_silent", silent, 0);
        end

        // Full scale: target 60 << 10 = 61440
        gap(300);
        check("full_level_59_60", int'(level == 6'd59 || level == 6'd60), 1);
        ones = 0;
        repeat (65536) begin
            tick();
            ones += dsm_out;
        end
        check("full_density", int'(ones >= 61432 && ones <= 61448), 1);

        // Full ramp down; mute and first strobe on the same edge
        mute = 1'b1;
        for (int k = 15; k >= 0; k--) begin
            strobe();
            gap(3);
            check("down_gain", dut.gain, k);
        end
        check("down_silent", silent, 1);
        check("down_active", active, 0);

        // Up to 8, reverse for 3 strobes, then back up
        mute = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            strobe();
            check("rev_up_gain", dut.gain, k);
        end
        mute = 1'b1;
        for (int k = 7; k >= 5; k--) begin
            strobe();
            gap(2);
            check("rev_down_gain", dut.gain, k);
        end
        mute = 1'b0;
        for (int k = 6; k <= 16; k++) begin
            strobe();
            check("rev_reup_gain", dut.gain, k);
        end
        strobe();
        gap(4);
        check("active_hold_gain", dut.gain, 16);
        check("active_flag", active, 1);

        // Latency and decay
        set_all(4'd0);
        gap(200);
        check("idle_y", dut.y, 0);
        pulse1_in = 4'd8;
        tick();
        check("lat_y_n", dut.y, 0);
        tick();
        check("lat_y_n1", dut.y, 0);
        tick();
        check("lat_y_n2", dut.y, 1024);
        check("lat_level", level, 1);
        pulse1_in = 4'd0;
        gap(200);
        check("decay_y", dut.y, 0);
        ones = 0;
        repeat (100) begin
            tick();
            ones += dsm_out;
        end
        check("decay_ones", ones, 0);

        // Reset during playback
        set_all(4'd15);
        gap(50);
        check("play_y_nonzero", int'(dut.y != 16'd0), 1);
        rst_n = 1'b0;
        tick();
        check("mrst_gain", dut.gain, 0);
        check("mrst_y", dut.y, 0);
        check("mrst_acc", dut.acc, 0);
        check("mrst_mix", dut.mix_q, 0);
        check("mrst_scaled", dut.scaled_q, 0);
        check("mrst_dsm_out", dsm_out, 0);
        check("mrst_level", level, 0);
        check("mrst_silent", silent, 1);
        check("mrst_active", active, 0);
        rst_n = 1'b1;
        tick();
        check("restart_gain0", dut.gain, 0);
        strobe();
        check("restart_gain1", dut.gain, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apu_dsm_dac.md
# apu_dsm_dac

Audio output stage for the APU. It takes the four 4-bit channel outputs (pulse 1, pulse 2, triangle, noise), mixes them and applies a click-free mute/unmute gain ramp. The result is smoothed by a one-pole IIR low-pass filter and converted to a 1-bit first-order delta-sigma stream, which drives the board audio pin through an external RC filter. It sits directly downstream of the channel generators and takes the place of the linear-sum PWM output.

## Interface
- `SHIFT`, default 3: IIR coefficient exponent, alpha = 2^-SHIFT; legal range 1..8.
- `apu_clk` in 1: APU clock, ~1.79 MHz.
- `rst_n` in 1: synchronous, active-low reset.
- `enable_240hz` in 1: one-cycle frame strobe; paces the gain ramp.
- `mute` in 1: 1 = ramp to silence, 0 = ramp to full gain; level-sensitive.
- `pulse1_in`, `pulse2_in`, `tri_in`, `noise_in` in 4 each: channel amplitudes 0..15.
- `dsm_out` out 1: delta-sigma bitstream.
- `level` out 6: filtered output level, y[15:10], for monitoring.
- `active` out 1: high when gain == 16 (full gain, ramp finished).
- `silent` out 1: high when gain == 0.

## Operation
- Stage 1: mix_q <= p1 + p2 + tri + noise, unsigned 6-bit, range 0..60, no saturation needed.
- Gain register: 5-bit, range 0..16.
- State machine: MUTED, RAMP_UP, ACTIVE, RAMP_DOWN.
  - MUTED (gain 0): go to RAMP_UP when mute == 0.
  - RAMP_UP: gain +1 on each enable_240hz. Go to ACTIVE when gain reaches 16. If mute == 1, go to RAMP_DOWN.
  - ACTIVE (gain 16): go to RAMP_DOWN when mute == 1.
  - RAMP_DOWN: gain -1 on each enable_240hz. Go to MUTED when gain reaches 0. If mute == 0, go to RAMP_UP.
  - Direction reversal mid-ramp continues from the current gain, with no jump.
  - Gain never leaves 0..16.
- Stage 2: scaled_q <= (mix_q * gain) >> 4, 6-bit, range 0..60, floor.
- Stage 3 (IIR): y is a 16-bit unsigned register. d = (scaled_q << 10) - y, computed as 17-bit signed. y <= y + (d >>> SHIFT), arithmetic shift, floor.
  - Target x<<10 is at most 61440, so y never overflows.
  - For constant x, y settles in [x*1024 - (2^SHIFT - 1), x*1024].
  - Decaying toward 0, y reaches exactly 0, because a negative d floors to at least -1.
- Stage 4 (DSM): acc is a 16-bit unsigned register. {carry, acc} <= acc + y as a 17-bit add; dsm_out <= carry.
  - Ones density equals y/65536, so maximum density is 61440/65536 = 15/16.
- level = y[15:10], combinational from the y register.
- active and silent are decoded combinationally from the gain register.

## Timing
- Reset (rst_n low at a rising edge): mix_q, scaled_q, y, acc, dsm_out and gain all go to 0; state goes to MUTED. Outputs are then level 0, active 0, silent 1.
- Reset mid-ramp or mid-playback is immediate on the next edge. No ramp-down is performed.
- First cycle after reset release with mute == 0: state goes to RAMP_UP. Gain stays 0 until the next enable_240hz.
- Pipeline latency from channel inputs to dsm_out: inputs sampled at edge n, mix_q valid n, scaled_q n+1, y updated n+2, dsm_out n+3. The IIR adds further settling time.
- Ramp duration: 16 enable_240hz strobes, about 66.7 ms, from MUTED to ACTIVE or the reverse.
- enable_240hz and a mute change on the same edge: the state transition and the gain step both take effect on that edge. The step direction follows the new state.
- enable_240hz in MUTED or ACTIVE: no gain change.
- No handshake; all inputs are assumed synchronous to apu_clk.

## Test plan
- Reset: hold rst_n low 2 cycles with all inputs at 15 → dsm_out 0, level 0, active 0, silent 1. After release with mute = 1 and 100 enable strobes → gain stays 0, dsm_out stays 0.
- Ramp up: mute = 0, pulse enable_240hz every 7458 cycles → active rises on the 16th strobe (not before) and silent falls on the 1st strobe.
- Full scale: all channels 15, state ACTIVE, y settled → ones in dsm_out over 65536 cycles = 61440 ±8 (±2^SHIFT); level = 59 or 60.
- Mute reversal: mute = 1 after 8 ramp strobes, then mute = 0 after 3 more strobes → gain sequence 8, 7, 6, 5, then rising 6 …; no step greater than 1 per strobe.
- Latency and decay: in ACTIVE with y = 0, step pulse1_in from 0 to 8 at edge n → y first nonzero at edge n+2, y = 1024 (SHIFT = 3). Step back to 0 → y reaches exactly 0 and dsm_out stays 0 from then on.
- Mid-operation reset: assert rst_n during ACTIVE playback → on the next edge all registers are 0 and state is MUTED; after release the ramp restarts from gain 0.
